shift_ctrl: RTL and testbench
=============================

Name: shift_ctrl

Overview:
Sequencer that sits directly upstream of the 8-bit mode-controlled shift register and drives its mode, parallel-load and serial-data inputs. Accepts a transfer request (word, direction, shift count) on a valid/ready handshake. Emits one LOAD cycle, then N LEFT or RIGHT shift cycles feeding a serial stream, then HOLD. Pulses done when the transfer completes; supports abort mid-transfer.

Parameters:
WIDTH, 8, width of the downstream register and of data_i/par_o; also the maximum shift count
CW, $clog2(WIDTH+1), width of len_i and cnt_o (4 at default; derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start_i  input  1  transfer request; accepted when start_i & ready_o
data_i  input  WIDTH  word to parallel-load, captured on accept
dir_i  input  1  0 = shift left (mode 10), 1 = shift right (mode 11); captured on accept
len_i  input  CW  number of shift cycles; captured on accept
ser_i  input  1  serial bit stream forwarded to the register's serial input during shifting
abort_i  input  1  cancel an in-flight transfer
ready_o  output  1  high only in IDLE
busy_o  output  1  high in LOAD and SHIFT
mode_o  output  2  to register mode input: 00 HOLD, 01 LOAD, 10 LEFT, 11 RIGHT
par_o  output  WIDTH  to register parallel input; holds the captured word
d_o  output  1  to register serial input
done_o  output  1  one-cycle completion pulse
cnt_o  output  CW  shift cycles remaining

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state IDLE, par_o 0, cnt_o 0, dir 0, done_o 0, mode_o 00, d_o 0, ready_o 1, busy_o 0.
- FSM states: IDLE, LOAD, SHIFT, DONE. mode_o, ready_o, busy_o, done_o and d_o are decoded from state (Moore), except that d_o is also combinational from ser_i during SHIFT.
- IDLE: mode 00, ready_o 1. On start_i:
  - Capture data_i to par_o and dir_i to dir.
  - Load cnt with len_i, saturated: any value > WIDTH becomes WIDTH.
  - Go to LOAD.
- LOAD (1 cycle): mode 01, par_o stable. Go to SHIFT if cnt != 0; if cnt == 0, go directly to DONE.
- SHIFT: mode 10 if dir = 0, 11 if dir = 1. d_o = ser_i. cnt decrements each cycle; when cnt == 1, go to DONE. Exactly cnt shift cycles occur.
- DONE (1 cycle): mode 00, done_o 1, ready_o 0. Go to IDLE.
- d_o = 0 in every state except SHIFT. par_o holds its value until the next accept.
- Latency at len = L (1..WIDTH), with start accepted at edge 0:
  - LOAD: cycle 1.
  - SHIFT: cycles 2..L+1.
  - DONE: cycle L+2.
  - ready_o high again: cycle L+3.
  - At L = 0: DONE at cycle 2.
- Boundaries:
  - start_i outside IDLE: ignored, not queued.
  - abort_i in LOAD or SHIFT: next state IDLE, mode 00 next cycle, no done_o pulse, cnt cleared to 0.
  - abort_i in IDLE or DONE: ignored; the DONE pulse still occurs.
  - abort_i and start_i together in IDLE: start is accepted.
  - rst asserted mid-transfer: reset values on the next edge; rst has priority over all other inputs.
  - Back-to-back transfers: minimum one IDLE cycle between DONE and the next LOAD.

Test Plan:
- Reset then idle: rst high 2 cycles -> mode_o 00, ready_o 1, par_o 00, done_o 0, cnt_o 0.
- Left load+shift: start, data 8'hA5, dir 0, len 3, ser_i 1 -> mode sequence 01,10,10,10,00. done_o at cycle 5, cnt_o 3→2→1→0, d_o 1 only during the 3 shift cycles. A shift_reg model attached reads P = 8'h2F.
- Right full shift: data 8'h81, dir 1, len 8, ser_i alternating 0/1 -> 8 cycles of mode 11, done_o at cycle 10. Modelled P equals the reversed ser_i sequence.
- len edge cases: len 0 -> LOAD then DONE, no SHIFT cycles, done_o at cycle 2. len 15 -> saturates to 8 shifts.
- Abort: len 8, assert abort_i during the 4th shift cycle -> next cycle mode 00, ready_o 1, no done_o. A new start is accepted the following cycle.
- Ignored start: pulse start_i with data 8'hFF during SHIFT -> par_o unchanged, transfer completes normally. Mid-transfer rst -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/shift_ctrl_if.sv
// Request/response bundle between a transfer initiator and shift_ctrl.
// The initiator takes the master modport and shift_ctrl takes the slave modport.
interface shift_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start_i;
  logic [WIDTH-1:0] data_i;
  logic             dir_i;
  logic [CW-1:0]    len_i;
  logic             ser_i;
  logic             abort_i;
  logic             ready_o;
  logic             busy_o;
  logic [1:0]       mode_o;
  logic [WIDTH-1:0] par_o;
  logic             d_o;
  logic             done_o;
  logic [CW-1:0]    cnt_o;

  modport master (
    output start_i, data_i, dir_i, len_i, ser_i, abort_i,
    input  ready_o, busy_o, mode_o, par_o, d_o, done_o, cnt_o
  );

  modport slave (
    input  start_i, data_i, dir_i, len_i, ser_i, abort_i,
    output ready_o, busy_o, mode_o, par_o, d_o, done_o, cnt_o
  );
endinterface

// File: rtl/shift_ctrl.sv
// Sequencer for the downstream mode-controlled shift register. Each transfer is
// one LOAD cycle, then len shift cycles fed from ser_i, then a one-cycle DONE pulse.
module shift_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  shift_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          par_d   = bus.data_i;
          dir_d   = bus.dir_i;
          cnt_d   = (bus.len_i > MAX_CNT) ? MAX_CNT : bus.len_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.abort_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = (cnt_q != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (bus.abort_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    mode_d  = MODE_HOLD;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
    case (state_d)
      S_LOAD:  mode_d = MODE_LOAD;
      S_SHIFT: mode_d = {1'b1, dir_d};
      default: mode_d = MODE_HOLD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      par_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The serial bit passes straight through during SHIFT so the register sees it the same cycle.
  assign bus.d_o     = (state_q == S_SHIFT) & bus.ser_i;
  assign bus.mode_o  = mode_q;
  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.par_o   = par_q;
  assign bus.cnt_o   = cnt_q;
endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: directed transfers followed by random traffic,
// compared against a per-transfer expected-trace model and an attached shift register.
module tb_shift_ctrl;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_ctrl_if #(.WIDTH(WIDTH)) bus ();
  shift_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // One entry per expected cycle of a transfer; an empty queue means IDLE.
  typedef struct {
    logic [1:0] mode;
    int         cnt;
    bit         load;
    bit         shift;
    bit         done;
  } step_t;

  step_t            trace[$];
  bit               bits[$];
  logic [WIDTH-1:0] par_m;
  bit               dir_m;
  int               n_vec  = 0;
  int               n_err  = 0;
  bit               chk_en = 1'b0;

  // Behavioural copy of the downstream register, driven only by the DUT outputs.
  logic [WIDTH-1:0] p_reg;
  always @(posedge clk) begin
    case (bus.mode_o)
      2'b01:   p_reg <= bus.par_o;
      2'b10:   p_reg <= {p_reg[WIDTH-2:0], bus.d_o};
      2'b11:   p_reg <= {bus.d_o, p_reg[WIDTH-1:1]};
      default: p_reg <= p_reg;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Register contents after the recorded shifts, by plain arithmetic.
  function automatic logic [WIDTH-1:0] expect_p();
    int p = int'(par_m);
    foreach (bits[i]) begin
      if (dir_m) p = (p / 2) + (bits[i] ? (1 << (WIDTH - 1)) : 0);
      else       p = ((p * 2) % (1 << WIDTH)) + (bits[i] ? 1 : 0);
    end
    return WIDTH'(p);
  endfunction

  task automatic set_in(input bit st, input logic [WIDTH-1:0] dt, input bit dr,
                        input logic [CW-1:0] ln, input bit sr, input bit ab, input bit rs);
    bus.start_i = st;
    bus.data_i  = dt;
    bus.dir_i   = dr;
    bus.len_i   = ln;
    bus.ser_i   = sr;
    bus.abort_i = ab;
    rst         = rs;
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic step();
    step_t e;
    bit    idle;
    int    ls;
    #1;
    idle = (trace.size() == 0);
    if (idle) e = '{mode: 2'b00, cnt: 0, load: 1'b0, shift: 1'b0, done: 1'b0};
    else      e = trace[0];
    if (chk_en) begin
      check("ready", 32'(bus.ready_o), 32'(idle));
      check("busy",  32'(bus.busy_o),  32'(e.load | e.shift));
      check("mode",  32'(bus.mode_o),  32'(e.mode));
      check("done",  32'(bus.done_o),  32'(e.done));
      check("cnt",   32'(bus.cnt_o),   32'(e.cnt));
      check("par",   32'(bus.par_o),   32'(par_m));
      check("d",     32'(bus.d_o),     32'(e.shift ? bus.ser_i : 1'b0));
      if (e.done) check("p_reg", 32'(p_reg), 32'(expect_p()));
    end
    if (rst) begin
      trace.delete();
      par_m = '0;
    end else if (!idle) begin
      if (bus.abort_i && (e.load || e.shift)) begin
        trace.delete();
      end else begin
        if (e.shift) bits.push_back(bus.ser_i);
        void'(trace.pop_front());
      end
    end else if (bus.start_i) begin
      par_m = bus.data_i;
      dir_m = bus.dir_i;
      bits.delete();
      ls = (int'(bus.len_i) > WIDTH) ? WIDTH : int'(bus.len_i);
      trace.push_back('{mode: 2'b01, cnt: ls, load: 1'b1, shift: 1'b0, done: 1'b0});
      for (int k = 0; k < ls; k++)
        trace.push_back('{mode: (bus.dir_i ? 2'b11 : 2'b10), cnt: ls - k,
                          load: 1'b0, shift: 1'b1, done: 1'b0});
      trace.push_back('{mode: 2'b00, cnt: 0, load: 1'b0, shift: 1'b0, done: 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, WIDTH'($urandom), 1'b0, '0, 1'($urandom), 1'b0, 1'b0);
      step();
    end
  endtask

  // ser_pat: 0 = all ones, 1 = alternating, 2 = random. *_cyc count from accept (1 = LOAD).
  task automatic run_xfer(input logic [WIDTH-1:0] dt, input bit dr, input logic [CW-1:0] ln,
                          input int ser_pat, input int abort_cyc, input int ff_cyc,
                          input int rst_cyc);
    int  c;
    bit  sr;
    bit  st;
    set_in(1'b1, dt, dr, ln, 1'b1, 1'b0, 1'b0);
    step();
    c = 1;
    while (trace.size() != 0 && c < 40) begin
      case (ser_pat)
        0:       sr = 1'b1;
        1:       sr = 1'(c % 2);
        default: sr = 1'($urandom);
      endcase
      st = (c == ff_cyc);
      set_in(st, st ? {WIDTH{1'b1}} : WIDTH'($urandom), 1'($urandom), CW'($urandom),
             sr, (c == abort_cyc), (c == rst_cyc));
      step();
      c++;
    end
  endtask

  initial begin
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    par_m = '0;
    dir_m = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    step();
    idle_steps(2);

    run_xfer(8'hA5, 1'b0, CW'(3), 0, -1, -1, -1);
    idle_steps(1);
    run_xfer(8'h81, 1'b1, CW'(8), 1, -1, -1, -1);
    idle_steps(1);
    run_xfer(8'h3C, 1'b0, CW'(0), 2, -1, -1, -1);
    idle_steps(1);
    run_xfer(8'h5A, 1'b1, CW'(15), 2, -1, -1, -1);
    idle_steps(1);
    run_xfer(8'hC3, 1'b0, CW'(8), 2, 5, -1, -1);
    run_xfer(8'h96, 1'b1, CW'(4), 2, -1, -1, -1);
    idle_steps(1);
    run_xfer(8'h12, 1'b0, CW'(6), 2, -1, 3, -1);
    idle_steps(1);
    run_xfer(8'h77, 1'b1, CW'(7), 2, -1, -1, 4);
    idle_steps(2);

    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom % 4) == 0, WIDTH'($urandom), 1'($urandom), CW'($urandom % 16),
             1'($urandom), ($urandom % 8) == 0, ($urandom % 64) == 0);
      step();
    end
    idle_steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
